irq_priority_ctrl: RTL
======================

// Module: irq_priority_ctrl
// PURPOSE
// - Fixed-priority interrupt controller that feeds the single 'interrupt' input of the jump control block.
// - Latches rising edges on N_IRQ request lines and arbitrates among them, lowest index wins.
// - Issues a one-cycle interrupt pulse together with a 16-bit vector address.
// - Blocks further interrupts until the handler's return-from-interrupt opcode reaches execute; no nesting.
// PARAMETERS
// N_IRQ       4            number of request lines, 2..16
// ID_W        2            width of irq_id, equals clog2(N_IRQ)
// VEC_BASE    16'h0F00     vector address of irq 0
// VEC_STRIDE  16'h0004     address step between consecutive vectors
// RETI_OP     6'b011110    execute-stage opcode that ends the service routine
// PORTS
// clk         in   1      system clock; all state changes on the rising edge
// reset       in   1      asynchronous, active-low reset
// irq_req     in   N_IRQ  request lines; a rising edge creates a pending request
// irq_mask    in   N_IRQ  1 = line enabled for arbitration
// global_en   in   1      1 = new interrupts may be issued
// op          in   6      opcode currently in execute
// op_valid    in   1      op is a real (non-bubble) instruction
// interrupt   out  1      one-cycle pulse to the jump control block
// int_vector  out  16     handler address; valid during the interrupt pulse, held until the next issue
// irq_id      out  ID_W   index of the line being serviced
// irq_ack     out  N_IRQ  one-hot acknowledge, asserted in the same cycle as interrupt
// irq_active  out  1      high in ISSUE and SERVICE
// pending     out  N_IRQ  current pending register
// BEHAVIOUR
// - Reset (asynchronous, while reset=0):
//   - State goes to IDLE; req_q, pending, irq_id and int_vector are cleared.
//   - All outputs are 0.
//   - A reset mid-service aborts the service and discards all pending requests.
// - Edge capture:
//   - req_q <= irq_req every cycle; edge = irq_req & ~req_q.
//   - pending |= edge. A line that is already high when reset is released counts as an edge.
//   - Dropping irq_req never clears pending.
//   - Masking a line does not clear its pending bit; the bit stays latched until unmasked and served.
// - Arbitration: eligible = pending & irq_mask; the winner is the lowest set index of eligible.
// - FSM, all outputs registered:
//   - IDLE: if global_en && eligible != 0, go to ISSUE.
//     - On the same edge, irq_id <= winner.
//     - On the same edge, int_vector <= VEC_BASE + winner*VEC_STRIDE, truncated to 16 bits (wraps mod 2^16).
//   - ISSUE (exactly 1 cycle):
//     - interrupt = 1, irq_ack[irq_id] = 1, irq_active = 1.
//     - Always goes to SERVICE next.
//     - pending[irq_id] clears on exit, unless a new edge arrives on that same line in that cycle; the new edge wins and the bit stays set.
//   - SERVICE: irq_active = 1. When op_valid && op == RETI_OP, go to HOLDOFF. Otherwise stay.
//   - HOLDOFF (exactly 1 cycle): irq_active = 0, no issue. Gives the return jump a cycle to take effect. Then go to IDLE.
// - Latency: an edge sampled at edge k sets pending at k; interrupt is high from k+1 to k+2, provided the FSM is IDLE and the line is enabled.
// - Back-to-back service: the earliest next issue after a RETI seen at edge r is interrupt high from r+2 to r+3.
// - RETI_OP in IDLE or HOLDOFF is ignored. op is ignored when op_valid = 0.
// - global_en = 0 blocks only the IDLE->ISSUE transition; capture continues and an in-progress service is unaffected.
// - Simultaneous edges on several lines all latch; they are served one per service cycle in index order.
// TESTING
// - Reset/idle: reset=0 then 1 with irq_req=0 -> all outputs 0 and state IDLE; force reset=0 mid-SERVICE -> outputs 0 immediately (asynchronous).
// - Single request: irq_req[2] rises before edge k -> interrupt=1, irq_ack=4'b0100, irq_id=2 and int_vector=16'h0F08 during k+1..k+2; pending=0 after.
// - Priority: irq_req=4'b1010 rises together -> line 1 served first (vector 16'h0F04); RETI (op=6'b011110, op_valid=1) -> after HOLDOFF, line 3 served (vector 16'h0F0C).
// - Mask/enable: irq_mask=4'b1110 with irq_req[0] edge -> no interrupt and pending=4'b0001; set mask bit 0 -> issue within 2 cycles. Same check with global_en=0 then 1.
// - No nesting/RETI gating: a new edge during SERVICE only sets pending. op=RETI_OP with op_valid=0 -> stays in SERVICE. RETI in IDLE -> no effect.
// - Re-edge on the served line: toggle irq_req[0] so a new edge lands in the ISSUE cycle -> pending[0] stays 1 and is served again after RETI.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// ---------------------------------------------------------------------------
// irq_priority_ctrl
//
// Fixed-priority interrupt controller driving the single 'interrupt' input of
// the jump control block. Rising edges on the request lines are latched into
// a pending register. The lowest-index pending, enabled line wins. The winner
// is issued as a one-cycle interrupt pulse together with its vector address.
// Further issues are blocked until the handler's return-from-interrupt opcode
// reaches execute, so interrupts never nest.
//
// Ports
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous, active-low reset
//   irq_req     in   N_IRQ  request lines; a rising edge creates a pending request
//   irq_mask    in   N_IRQ  1 = line enabled for arbitration
//   global_en   in   1      1 = new interrupts may be issued
//   op          in   6      opcode currently in execute
//   op_valid    in   1      op is a real (non-bubble) instruction
//   interrupt   out  1      one-cycle pulse to the jump control block
//   int_vector  out  16     handler address, held until the next issue
//   irq_id      out  ID_W   index of the line being serviced
//   irq_ack     out  N_IRQ  one-hot acknowledge, coincident with interrupt
//   irq_active  out  1      high while issuing and servicing
//   pending     out  N_IRQ  current pending register
//
// States
//   state       | meaning
//   ST_IDLE     | waiting for an enabled pending request
//   ST_ISSUE    | one-cycle interrupt pulse and acknowledge
//   ST_SERVICE  | handler running; waiting for a valid RETI in execute
//   ST_HOLDOFF  | one idle cycle so the return jump takes effect
// ---------------------------------------------------------------------------
module irq_priority_ctrl #(
  parameter int          N_IRQ      = 4,
  parameter int          ID_W       = 2,
  parameter logic [15:0] VEC_BASE   = 16'h0F00,
  parameter logic [15:0] VEC_STRIDE = 16'h0004,
  parameter logic [5:0]  RETI_OP    = 6'b011110
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq_req,
  input  logic [N_IRQ-1:0]  irq_mask,
  input  logic              global_en,
  input  logic [5:0]        op,
  input  logic              op_valid,
  output logic              interrupt,
  output logic [15:0]       int_vector,
  output logic [ID_W-1:0]   irq_id,
  output logic [N_IRQ-1:0]  irq_ack,
  output logic              irq_active,
  output logic [N_IRQ-1:0]  pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_SERVICE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  state_t            state;
  logic [N_IRQ-1:0]  req_q;
  logic [N_IRQ-1:0]  req_rise;
  logic [N_IRQ-1:0]  eligible;
  logic [N_IRQ-1:0]  pending_clr;
  logic [N_IRQ-1:0]  pending_nxt;
  logic [N_IRQ-1:0]  ack_nxt;
  logic [ID_W-1:0]   winner;
  logic              win_found;
  logic [15:0]       vec_nxt;
  logic              reti_seen;

  // req_q clears on reset, so a line already high at reset release counts
  // as a fresh edge.
  assign req_rise = irq_req & ~req_q;
  assign eligible = pending & irq_mask;

  // Priority encoder: scanning downwards leaves the lowest set index.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner    = ID_W'(i);
        win_found = 1'b1;
      end
    end
  end

  // 16-bit arithmetic wraps the vector modulo 2^16.
  assign vec_nxt   = VEC_BASE + (16'(winner) * VEC_STRIDE);
  assign ack_nxt   = N_IRQ'(1) << winner;
  assign reti_seen = op_valid && (op == RETI_OP);

  // The served bit is dropped when leaving ISSUE. A new edge on that line
  // in the same cycle is OR-ed in afterwards, so the re-request is kept.
  assign pending_clr = (state == ST_ISSUE) ? (N_IRQ'(1) << irq_id) : '0;
  assign pending_nxt = (pending & ~pending_clr) | req_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q   <= '0;
      pending <= '0;
    end else begin
      req_q   <= irq_req;
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      interrupt  <= 1'b0;
      irq_ack    <= '0;
      irq_active <= 1'b0;
      irq_id     <= '0;
      int_vector <= '0;
    end else begin
      interrupt <= 1'b0;
      irq_ack   <= '0;
      case (state)
        ST_IDLE: begin
          if (global_en && win_found) begin
            state      <= ST_ISSUE;
            interrupt  <= 1'b1;
            irq_ack    <= ack_nxt;
            irq_active <= 1'b1;
            irq_id     <= winner;
            int_vector <= vec_nxt;
          end
        end
        ST_ISSUE: begin
          state <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (reti_seen) begin
            state      <= ST_HOLDOFF;
            irq_active <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          state <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          irq_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
